vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Three-port single-cycle VRAM arbiter: port 0 display fetch, port 1 CPU, port 2 sprite/aux.
// Define VRAM_ARB_STARVE_GUARD_EN to let a starving port 1/2 request override port 0.
module vram_arbiter #(
  parameter int VRAM_SIZE_BYTES = 131072,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [14:0] p0_addr,
  input  logic        p0_write,
  input  logic [31:0] p0_wrdata,
  input  logic [3:0]  p0_wrbytesel,
  output logic        p0_ack,
  output logic [31:0] p0_rddata,
  output logic        p0_rddata_valid,
  input  logic        p1_req,
  input  logic [14:0] p1_addr,
  input  logic        p1_write,
  input  logic [31:0] p1_wrdata,
  input  logic [3:0]  p1_wrbytesel,
  output logic        p1_ack,
  output logic [31:0] p1_rddata,
  output logic        p1_rddata_valid,
  input  logic        p2_req,
  input  logic [14:0] p2_addr,
  input  logic        p2_write,
  input  logic [31:0] p2_wrdata,
  input  logic [3:0]  p2_wrbytesel,
  output logic        p2_ack,
  output logic [31:0] p2_rddata,
  output logic        p2_rddata_valid,
  output logic [14:0] bus_addr,
  output logic [31:0] bus_wrdata,
  output logic [3:0]  bus_wrbytesel,
  output logic        bus_write,
  input  logic [31:0] bus_rddata
);
  localparam int          WORDS     = VRAM_SIZE_BYTES / 4;
  localparam logic [14:0] ADDR_MASK = 15'(WORDS - 1);

  typedef enum logic [1:0] {GNT_NONE, GNT_P0, GNT_P1, GNT_P2} gnt_e;

  gnt_e       gnt;
  logic       rr_q, rr_d;           // 0: port 1 preferred, 1: port 2 preferred
  logic       rd_vld_q, rd_vld_d;
  logic [1:0] rd_port_q, rd_port_d;
  logic       starve1, starve2;

  function automatic gnt_e rr_pick(input logic r1, input logic r2, input logic prefer2);
    gnt_e g;
    g = GNT_NONE;
    if (r1 && (!r2 || !prefer2)) g = GNT_P1;
    else if (r2)                 g = GNT_P2;
    return g;
  endfunction

  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (starve1 || starve2) gnt = rr_pick(starve1, starve2, rr_q);
      else if (p0_req)        gnt = GNT_P0;
      else                    gnt = rr_pick(p1_req, p2_req, rr_q);
    end
  end

  assign p0_ack = (gnt == GNT_P0);
  assign p1_ack = (gnt == GNT_P1);
  assign p2_ack = (gnt == GNT_P2);

  always_comb begin
    bus_addr      = 15'd0;
    bus_wrdata    = 32'd0;
    bus_wrbytesel = 4'd0;
    bus_write     = 1'b0;
    rr_d          = rr_q;
    rd_vld_d      = 1'b0;
    rd_port_d     = rd_port_q;
    unique case (gnt)
      GNT_P0: begin
        bus_addr = p0_addr & ADDR_MASK; bus_wrdata = p0_wrdata;
        bus_wrbytesel = p0_wrbytesel; bus_write = p0_write;
        rd_vld_d = !p0_write; rd_port_d = 2'd0;
      end
      GNT_P1: begin
        bus_addr = p1_addr & ADDR_MASK; bus_wrdata = p1_wrdata;
        bus_wrbytesel = p1_wrbytesel; bus_write = p1_write;
        rd_vld_d = !p1_write; rd_port_d = 2'd1; rr_d = 1'b1;
      end
      GNT_P2: begin
        bus_addr = p2_addr & ADDR_MASK; bus_wrdata = p2_wrdata;
        bus_wrbytesel = p2_wrbytesel; bus_write = p2_write;
        rd_vld_d = !p2_write; rd_port_d = 2'd2; rr_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_port_q <= 2'd0;
    end else begin
      rr_q      <= rr_d;
      rd_vld_q  <= rd_vld_d;
      rd_port_q <= rd_port_d;
    end
  end

  // Read tag is masked during reset so a grant just before reset never reports data.
  assign p0_rddata_valid = !rst && rd_vld_q && (rd_port_q == 2'd0);
  assign p1_rddata_valid = !rst && rd_vld_q && (rd_port_q == 2'd1);
  assign p2_rddata_valid = !rst && rd_vld_q && (rd_port_q == 2'd2);
  assign p0_rddata = bus_rddata;
  assign p1_rddata = bus_rddata;
  assign p2_rddata = bus_rddata;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] wcnt1_q, wcnt1_d, wcnt2_q, wcnt2_d;

  assign starve1 = p1_req && (wcnt1_q == LIMIT);
  assign starve2 = p2_req && (wcnt2_q == LIMIT);

  always_comb begin
    wcnt1_d = 8'd0;
    wcnt2_d = 8'd0;
    if (p1_req && !p1_ack) wcnt1_d = (wcnt1_q == LIMIT) ? wcnt1_q : wcnt1_q + 8'd1;
    if (p2_req && !p2_ack) wcnt2_d = (wcnt2_q == LIMIT) ? wcnt2_q : wcnt2_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt1_q <= 8'd0;
      wcnt2_q <= 8'd0;
    end else begin
      wcnt1_q <= wcnt1_d;
      wcnt2_q <= wcnt2_d;
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign starve1 = 1'b0;
  assign starve2 = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized scoreboard bench for vram_arbiter with a cycle-level reference model and RAM model.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int LIMIT = 8;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req;
  logic [14:0] addr [3];
  logic        wr   [3];
  logic [31:0] wd   [3];
  logic [3:0]  be   [3];
  logic [2:0]  ack, vld;
  logic [31:0] rd0, rd1, rd2;
  logic [14:0] bus_addr;
  logic [31:0] bus_wrdata, bus_rddata;
  logic [3:0]  bus_wrbytesel;
  logic        bus_write;

  vram_arbiter #(.VRAM_SIZE_BYTES(131072), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_addr(addr[0]), .p0_write(wr[0]), .p0_wrdata(wd[0]), .p0_wrbytesel(be[0]),
    .p0_ack(ack[0]), .p0_rddata(rd0), .p0_rddata_valid(vld[0]),
    .p1_req(req[1]), .p1_addr(addr[1]), .p1_write(wr[1]), .p1_wrdata(wd[1]), .p1_wrbytesel(be[1]),
    .p1_ack(ack[1]), .p1_rddata(rd1), .p1_rddata_valid(vld[1]),
    .p2_req(req[2]), .p2_addr(addr[2]), .p2_write(wr[2]), .p2_wrdata(wd[2]), .p2_wrbytesel(be[2]),
    .p2_ack(ack[2]), .p2_rddata(rd2), .p2_rddata_valid(vld[2]),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wrbytesel(bus_wrbytesel),
    .bus_write(bus_write), .bus_rddata(bus_rddata)
  );

  // RAM device: registered read, byte-enabled write
  logic [31:0] ram    [0:32767];
  logic [31:0] refmem [0:32767];
  always @(posedge clk) begin
    bus_rddata <= ram[bus_addr];
    if (bus_write)
      for (int b = 0; b < 4; b++)
        if (bus_wrbytesel[b]) ram[bus_addr][8*b +: 8] <= bus_wrdata[8*b +: 8];
  end

  typedef struct {
    logic [2:0]  ack;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
    logic [2:0]  vld;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0, cyc = 0;

  // Reference model state
  int          rr_pref;
  int          wc [3];
  bit          tag_v;
  int          tag_p;
  logic [31:0] tag_d;
  int          last_g;

  function automatic int pick(bit r1, bit r2);
    if (r1 && r2) return rr_pref;
    if (r1) return 1;
    if (r2) return 2;
    return -1;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    int g;
    bit s1, s2;
    g = -1;
    s1 = 0; s2 = 0;
    if (!rst) begin
`ifdef VRAM_ARB_STARVE_GUARD_EN
      s1 = req[1] && (wc[1] >= LIMIT);
      s2 = req[2] && (wc[2] >= LIMIT);
`endif
      if (s1 || s2)    g = pick(s1, s2);
      else if (req[0]) g = 0;
      else             g = pick(req[1], req[2]);
    end
    e.ack   = (g < 0) ? 3'b000 : 3'(1 << g);
    e.addr  = (g < 0) ? 15'd0 : addr[g];
    e.wdata = (g < 0) ? 32'd0 : wd[g];
    e.be    = (g < 0) ? 4'd0  : be[g];
    e.wr    = (g < 0) ? 1'b0  : wr[g];
    e.vld   = (!rst && tag_v) ? 3'(1 << tag_p) : 3'b000;
    e.rdata = tag_d;
    exp_q.push_back(e);
    if (rst) begin
      rr_pref = 1; wc = '{0, 0, 0}; tag_v = 0;
    end else begin
      tag_v = (g >= 0) && !wr[g];
      if (tag_v) begin tag_p = g; tag_d = refmem[addr[g]]; end
      if (g >= 0 && wr[g])
        for (int b = 0; b < 4; b++)
          if (be[g][b]) refmem[addr[g]][8*b +: 8] = wd[g][8*b +: 8];
      for (int n = 1; n < 3; n++)
        if (req[n] && g != n) wc[n] = (wc[n] < LIMIT) ? wc[n] + 1 : LIMIT;
        else                  wc[n] = 0;
      if (g == 1) rr_pref = 2;
      else if (g == 2) rr_pref = 1;
    end
    last_g = g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(int n, logic [14:0] a, logic w, logic [31:0] d, logic [3:0] b);
    req[n] = 1'b1; addr[n] = a; wr[n] = w; wd[n] = d; be[n] = b;
  endtask

  task automatic rand_req(int n);
    new_req(n, 15'($urandom), 1'($urandom_range(1)), $urandom, 4'($urandom_range(15, 1)));
  endtask

  task automatic retire();
    if (last_g >= 0) req[last_g] = 1'b0;
  endtask

  task automatic rand_cycle(int p0_pct, int lo_pct);
    retire();
    for (int n = 0; n < 3; n++) begin
      if (req[n] && n != 0 && $urandom_range(99) < 3) req[n] = 1'b0;
      else if (!req[n] && $urandom_range(99) < ((n == 0) ? p0_pct : lo_pct)) rand_req(n);
    end
    rst = ($urandom_range(199) == 0);
    step();
  endtask

  // Monitor: pops one expected record per cycle and compares mid-cycle
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty cycle=%0d actual=empty required=record", cyc);
      end else begin
        e = exp_q.pop_front();
        cmp("ack", 32'(ack), 32'(e.ack));
        cmp("bus_addr", 32'(bus_addr), 32'(e.addr));
        cmp("bus_wrdata", bus_wrdata, e.wdata);
        cmp("bus_wrbytesel", 32'(bus_wrbytesel), 32'(e.be));
        cmp("bus_write", 32'(bus_write), 32'(e.wr));
        cmp("rddata_valid", 32'(vld), 32'(e.vld));
        if (e.vld != 3'b000) begin
          cmp("p0_rddata", rd0, e.rdata);
          cmp("p1_rddata", rd1, e.rdata);
          cmp("p2_rddata", rd2, e.rdata);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = 3'b000; last_g = -1;
    rr_pref = 1; wc = '{0, 0, 0}; tag_v = 0; tag_p = 0; tag_d = 32'd0;
    for (int n = 0; n < 3; n++) begin addr[n] = '0; wr[n] = 0; wd[n] = '0; be[n] = '0; end
    for (int i = 0; i < 32768; i++) begin
      ram[i]    = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
      refmem[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    end
    ram[15'h0123] = 32'hDEADBEEF;
    refmem[15'h0123] = 32'hDEADBEEF;

    @(posedge clk); #1;
    repeat (3) step();

    // Single read in the first cycle out of reset
    rst = 1'b0;
    new_req(1, 15'h0123, 1'b0, 32'd0, 4'hF);
    step(); retire();
    step();

    // All three request together after a reset; p1/p2 then held and alternate
    rst = 1'b1; step(); rst = 1'b0;
    new_req(0, 15'h0010, 1'b0, 32'd0, 4'hF);
    new_req(1, 15'h0020, 1'b0, 32'd0, 4'hF);
    new_req(2, 15'h0030, 1'b1, 32'hCAFE0001, 4'hF);
    for (int i = 0; i < 8; i++) begin
      step(); retire();
      if (!req[1]) new_req(1, 15'(16'h0040 + i), 1'(i & 1), $urandom, 4'hF);
      if (!req[2]) new_req(2, 15'(16'h0050 + i), 1'b0, 32'd0, 4'hF);
    end
    req = 3'b000;
    step();

    // Byte write to the top word, then read it back
    new_req(2, 15'h7FFF, 1'b1, 32'h11223344, 4'b0101);
    step(); retire();
    new_req(1, 15'h7FFF, 1'b0, 32'd0, 4'hF);
    step(); retire();
    step();

    // Port 0 saturates the bus while port 1 waits
    for (int i = 0; i < 20; i++) begin
      retire();
      if (!req[0]) new_req(0, 15'($urandom), 1'b0, 32'd0, 4'hF);
      if (i == 0) new_req(1, 15'h0123, 1'b0, 32'd0, 4'hF);
      step();
    end
    retire(); req = 3'b000;
    step();

    // Reset in the cycle after a read grant
    new_req(0, 15'h0123, 1'b0, 32'd0, 4'hF);
    step(); retire();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Idle
    repeat (10) step();

    // Randomized traffic at several load mixes
    for (int i = 0; i < 600; i++) rand_cycle(30, 30);
    for (int i = 0; i < 600; i++) rand_cycle(95, 60);
    for (int i = 0; i < 400; i++) rand_cycle(5, 80);

    retire(); req = 3'b000; rst = 1'b0;
    step(); step();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain cycle=%0d actual=%0d required=0", cyc, exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
